// File: rtl/jt49_pkg.sv
// Shared definitions for the PSG clock-enable chain: default ratio width,
// reset ratio constants and the ratio validity check.
package jt49_pkg;

    localparam int W_DEF   = 16;
    localparam int N_RESET = 1;
    localparam int M_RESET = 8;

    // A ratio is usable when both terms are non-zero and 2n <= m, which keeps
    // the accumulator below m and limits the producer to one tick per clk.
    function automatic logic ratio_ok(input logic [31:0] n, input logic [31:0] m);
        logic [32:0] n2;
        n2 = {n, 1'b0};
        return (n != 32'd0) && (m != 32'd0) && (n2 <= {1'b0, m});
    endfunction

endpackage

// File: rtl/jt49_frac_acc.sv
// Fractional accumulator: adds 2n per enabled clk and wraps modulo m,
// flagging tick in the same clk as the wrap.
module jt49_frac_acc #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] n,
    input  logic [W-1:0] m,
    output logic         tick
);

    logic [W:0] acc;
    logic [W:0] sum;

    // With 2n <= m and acc < m the sum stays below 2m, so W+1 bits suffice.
    always_comb begin
        sum  = acc + {n, 1'b0};
        tick = en && (sum >= {1'b0, m});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            if (clr)
                acc <= '0;
            else if (tick)
                acc <= sum - {1'b0, m};
            else
                acc <= sum;
        end
    end

endmodule

// File: rtl/jt49_frac_cen.sv
// Base chip clock-enable producer: cen/cenb at n/m pulses per clk each,
// with a shadowed runtime ratio that switches only on a cenb boundary.
module jt49_frac_cen
    import jt49_pkg::*;
#(
    parameter int W      = W_DEF,
    parameter int N_INIT = N_RESET,
    parameter int M_INIT = M_RESET
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         upd,
    input  logic [W-1:0] n_in,
    input  logic [W-1:0] m_in,
    output logic         cen,
    output logic         cenb,
    output logic         err,
    output logic         busy
);

    // Update handshake: upd is a single-clk strobe that is always taken.
    // A valid request clears err and raises busy until the ratio is applied;
    // an invalid one sets err and leaves both ratio and shadow untouched.

    logic [W-1:0] n_q, m_q;
    logic [W-1:0] n_sh, m_sh;
    logic         phase;
    logic         tick;
    logic         apply;
    logic         req_ok;

    always_comb begin
        req_ok = ratio_ok(32'(n_in), 32'(m_in));
        // Switch only on the tick that closes a cen/cenb pair.
        apply  = tick && phase && busy;
    end

    jt49_frac_acc #(.W(W)) u_acc (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .clr   (apply),
        .n     (n_q),
        .m     (m_q),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q   <= W'(N_INIT);
            m_q   <= W'(M_INIT);
            n_sh  <= W'(N_INIT);
            m_sh  <= W'(M_INIT);
            phase <= 1'b0;
            cen   <= 1'b0;
            cenb  <= 1'b0;
            err   <= 1'b0;
            busy  <= 1'b0;
        end else begin
            cen   <= tick && !phase;
            cenb  <= tick && phase;
            phase <= phase ^ tick;
            if (apply) begin
                n_q  <= n_sh;
                m_q  <= m_sh;
                busy <= 1'b0;
            end
            // A request landing on the apply clk re-arms busy with new data.
            if (upd) begin
                if (req_ok) begin
                    err  <= 1'b0;
                    n_sh <= n_in;
                    m_sh <= m_in;
                    busy <= 1'b1;
                end else begin
                    err  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_jt49_frac_cen.sv
// Directed bench for jt49_frac_cen: expected pulses are queued with their
// clk index and a negedge monitor pops and compares every pulse seen.
module tb_jt49_frac_cen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        upd;
    logic [15:0] n_in;
    logic [15:0] m_in;
    logic        cen;
    logic        cenb;
    logic        err;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // {clk index, cen, cenb}
    logic [33:0] exp_q[$];

    int win_lo = -1;
    int win_hi = -1;
    int cen_cnt = 0;
    int cenb_cnt = 0;
    int last_cen = -1;
    int last_cenb = -1;

    jt49_frac_cen #(.W(16), .N_INIT(1), .M_INIT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .upd   (upd),
        .n_in  (n_in),
        .m_in  (m_in),
        .cen   (cen),
        .cenb  (cenb),
        .err   (err),
        .busy  (busy)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at clk %0d", cyc);
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (clk %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int e, input logic c, input logic cb);
        exp_q.push_back({32'(e), c, cb});
    endtask

    task automatic wait_until(input int e);
        while (cyc < e) @(negedge clk);
    endtask

    task automatic do_upd(input logic [15:0] n, input logic [15:0] m);
        n_in = n;
        m_in = m;
        upd  = 1'b1;
        @(negedge clk);
        upd  = 1'b0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [33:0] obs;
        logic [33:0] exp;
        while (exp_q.size() > 0 && int'(exp_q[0][33:2]) < cyc) begin
            exp = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL pulse_missing: none at clk %0d, expected cen=%0d cenb=%0d",
                     exp[33:2], exp[1], exp[0]);
        end
        if (rst_n && (cen || cenb)) begin
            obs = {32'(cyc), cen, cenb};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pulse_unexpected: clk %0d cen=%0d cenb=%0d, expected none",
                         cyc, cen, cenb);
            end else begin
                exp = exp_q.pop_front();
                if (obs !== exp) begin
                    errors++;
                    $display("FAIL pulse: got clk %0d cen=%0d cenb=%0d, expected clk %0d cen=%0d cenb=%0d",
                             cyc, cen, cenb, exp[33:2], exp[1], exp[0]);
                end
            end
            if (cyc >= win_lo && cyc <= win_hi) begin
                if (cen) begin
                    if (last_cen >= 0) begin
                        checks++;
                        if (cyc - last_cen < 2 || cyc - last_cen > 3) begin
                            errors++;
                            $display("FAIL cen_gap: got %0d clk, expected 2 or 3", cyc - last_cen);
                        end
                    end
                    last_cen = cyc;
                    cen_cnt++;
                end
                if (cenb) begin
                    if (last_cenb >= 0) begin
                        checks++;
                        if (cyc - last_cenb < 2 || cyc - last_cenb > 3) begin
                            errors++;
                            $display("FAIL cenb_gap: got %0d clk, expected 2 or 3", cyc - last_cenb);
                        end
                    end
                    last_cenb = cyc;
                    cenb_cnt++;
                end
            end
        end
    end

    // stimulus
    initial begin
        int b;
        int r;
        int a;
        rst_n = 1'b0;
        en    = 1'b0;
        upd   = 1'b0;
        n_in  = '0;
        m_in  = '0;

        wait_until(2);
        chk("reset_cen", 32'(cen), 0);
        chk("reset_cenb", 32'(cenb), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_err", 32'(err), 0);

        // 1/8 from reset: a tick every 4 clk, cen and cenb alternating
        wait_until(3);
        b = cyc;
        rst_n = 1'b1;
        en    = 1'b1;
        for (int k = 1; k <= 8; k++) push_ev(b + 4 * k, k[0], ~k[0]);

        // en low for 10 clk after a cen: its cenb moves from b+40 to b+50
        push_ev(b + 36, 1'b1, 1'b0);
        push_ev(b + 50, 1'b0, 1'b1);
        push_ev(b + 54, 1'b1, 1'b0);
        wait_until(b + 37);
        en = 1'b0;
        wait_until(b + 47);
        en = 1'b1;

        // switch to 4/8 at the cenb on b+58, then a tick every clk
        push_ev(b + 58, 1'b0, 1'b1);
        for (int e = 59; e <= 68; e++) push_ev(b + e, e[0], ~e[0]);
        // 1/4 applied at b+68: cen every 4 clk
        push_ev(b + 70, 1'b1, 1'b0);
        push_ev(b + 72, 1'b0, 1'b1);
        push_ev(b + 74, 1'b1, 1'b0);
        push_ev(b + 76, 1'b0, 1'b1);
        push_ev(b + 78, 1'b1, 1'b0);
        push_ev(b + 80, 1'b0, 1'b1);
        wait_until(b + 55);
        do_upd(16'd4, 16'd8);
        chk("upd48_busy", 32'(busy), 1);
        chk("upd48_err", 32'(err), 0);
        wait_until(b + 58);
        chk("apply48_busy", 32'(busy), 0);
        wait_until(b + 62);
        do_upd(16'd5, 16'd8);
        chk("bad58_err", 32'(err), 1);
        chk("bad58_busy", 32'(busy), 0);
        wait_until(b + 65);
        do_upd(16'd1, 16'd4);
        chk("upd14_err", 32'(err), 0);
        chk("upd14_busy", 32'(busy), 1);
        wait_until(b + 67);
        chk("upd14_busy_after_cen", 32'(busy), 1);
        wait_until(b + 68);
        chk("apply14_busy", 32'(busy), 0);

        // back-to-back requests 1/16 then 1/32: only 1/32 applies at b+84
        push_ev(b + 82, 1'b1, 1'b0);
        push_ev(b + 84, 1'b0, 1'b1);
        push_ev(b + 100, 1'b1, 1'b0);
        wait_until(b + 80);
        n_in = 16'd1;
        m_in = 16'd16;
        upd  = 1'b1;
        @(negedge clk);
        m_in = 16'd32;
        @(negedge clk);
        upd  = 1'b0;
        chk("b2b_busy", 32'(busy), 1);
        wait_until(b + 84);
        chk("b2b_apply_busy", 32'(busy), 0);
        wait_until(b + 101);
        do_upd(16'd1, 16'd0);
        chk("m0_err", 32'(err), 1);
        wait_until(b + 103);
        do_upd(16'd1, 16'd32);
        chk("upd132_err", 32'(err), 0);
        chk("upd132_busy", 32'(busy), 1);
        wait_until(b + 105);
        do_upd(16'd0, 16'd32);
        chk("n0_err", 32'(err), 1);
        chk("n0_busy_kept", 32'(busy), 1);

        // asynchronous reset while busy; the pending shadow is discarded
        wait_until(b + 107);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 0);
        chk("async_err", 32'(err), 0);
        chk("async_cen", 32'(cen), 0);
        chk("async_cenb", 32'(cenb), 0);
        wait_until(b + 109);
        r = cyc;
        rst_n = 1'b1;
        push_ev(r + 4, 1'b1, 1'b0);
        push_ev(r + 8, 1'b0, 1'b1);
        push_ev(r + 12, 1'b1, 1'b0);
        push_ev(r + 16, 1'b0, 1'b1);

        // 3/8 applied at r+16: each 4-clk block holds ticks on its last 3 clk
        a = r + 16;
        win_lo = a + 1;
        win_hi = a + 800;
        for (int k = 0; k < 600; k++)
            push_ev(a + 4 * (k / 3) + (k % 3) + 2, ~k[0], k[0]);
        wait_until(r + 9);
        do_upd(16'd3, 16'd8);
        chk("upd38_busy", 32'(busy), 1);
        wait_until(a);
        chk("apply38_busy", 32'(busy), 0);
        wait_until(a + 800);
        en = 1'b0;
        wait_until(a + 806);
        chk("cnt_cen_800", 32'(cen_cnt), 300);
        chk("cnt_cenb_800", 32'(cenb_cnt), 300);
        chk("exp_q_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
